// File: rtl/slc3_button_conditioner.sv
// slc3_button_conditioner: synchronizes and debounces the active-low Run/Continue
// pushbuttons, decodes press episodes into single-cycle pulses, turns a held
// two-button chord into a CPU reset request and snapshots SW on every Run pulse.
// Optional build macro: CONTINUE_REPEAT_EN (auto-repeat Continue while held).
module slc3_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES     = 64
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run_n,
  input  logic       Continue_n,
  input  logic [9:0] SW,
  output logic       Run_pulse,
  output logic       Continue_pulse,
  output logic       Sys_reset,
  output logic [9:0] SW_snap,
  output logic       Run_held,
  output logic       Continue_held
);

  localparam int unsigned SW_W   = 10;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  // Reject parameter values the counters cannot honour
  if (DEBOUNCE_CYCLES < 2 || RESET_HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("slc3_button_conditioner: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SINGLE_R = 3'd1,
    SINGLE_C = 3'd2,
    BOTH     = 3'd3,
    WAIT_REL = 3'd4
  } state_e;

  // Bit 0 = Run, bit 1 = Continue throughout the button datapath
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           held_q, held_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           pressed;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              run_pulse_q, run_pulse_d;
  logic              cont_pulse_q, cont_pulse_d;
  logic              sys_reset_q, sys_reset_d;
  logic [SW_W-1:0]   sw_snap_q, sw_snap_d;
  logic              run_h, cont_h;

`ifdef CONTINUE_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_fired_q, rep_fired_d;
`endif

  // Two-flop synchronizer, idles released (high)
  always_comb begin
    sync1_d = {Continue_n, Run_n};
    sync2_d = sync1_q;
  end

  assign pressed = ~sync2_q;

  // Per-button debounce: the level flips only after DEBOUNCE_CYCLES disagreeing cycles
  always_comb begin
    held_d   = held_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (pressed[i] != held_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          held_d[i]   = ~held_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Synchronizer and debounce state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      held_q   <= 2'b00;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      held_q   <= held_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign run_h  = held_q[0];
  assign cont_h = held_q[1];

  // Episode decoder: pulses only on a clean single-button release, chord -> reset
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    run_pulse_d  = 1'b0;
    cont_pulse_d = 1'b0;
    sys_reset_d  = sys_reset_q;
    sw_snap_d    = sw_snap_q;
`ifdef CONTINUE_REPEAT_EN
    rep_cnt_d    = rep_cnt_q;
    rep_fired_d  = rep_fired_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (run_h && cont_h) begin
          state_d    = BOTH;
          hold_cnt_d = HOLD_W'(1);
        end else if (run_h) begin
          state_d = SINGLE_R;
        end else if (cont_h) begin
          state_d = SINGLE_C;
`ifdef CONTINUE_REPEAT_EN
          rep_cnt_d   = '0;
          rep_fired_d = 1'b0;
`endif
        end
      end
      SINGLE_R: begin
        if (cont_h) begin
          state_d    = BOTH;
          hold_cnt_d = HOLD_W'(1);
        end else if (!run_h) begin
          state_d     = IDLE;
          run_pulse_d = 1'b1;
          sw_snap_d   = SW;
        end
      end
      SINGLE_C: begin
        if (run_h) begin
          state_d    = BOTH;
          hold_cnt_d = HOLD_W'(1);
        end else if (!cont_h) begin
          state_d = IDLE;
`ifdef CONTINUE_REPEAT_EN
          cont_pulse_d = ~rep_fired_q;
`else
          cont_pulse_d = 1'b1;
`endif
        end else begin
`ifdef CONTINUE_REPEAT_EN
          if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
            cont_pulse_d = 1'b1;
            rep_cnt_d    = '0;
            rep_fired_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
`endif
        end
      end
      BOTH: begin
        if (!(run_h && cont_h)) begin
          state_d = WAIT_REL;
        end else if (hold_cnt_q >= HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
          state_d     = WAIT_REL;
          sys_reset_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      WAIT_REL: begin
        if (!run_h && !cont_h) begin
          state_d     = IDLE;
          sys_reset_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        sys_reset_d = 1'b0;
      end
    endcase
  end

  // Episode FSM state and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      run_pulse_q  <= 1'b0;
      cont_pulse_q <= 1'b0;
      sys_reset_q  <= 1'b0;
      sw_snap_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      run_pulse_q  <= run_pulse_d;
      cont_pulse_q <= cont_pulse_d;
      sys_reset_q  <= sys_reset_d;
      sw_snap_q    <= sw_snap_d;
    end
  end

`ifdef CONTINUE_REPEAT_EN
  // Continue auto-repeat bookkeeping
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_cnt_q   <= '0;
      rep_fired_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_fired_q <= rep_fired_d;
    end
  end
`endif

  assign Run_pulse      = run_pulse_q;
  assign Continue_pulse = cont_pulse_q;
  assign Sys_reset      = sys_reset_q;
  assign SW_snap        = sw_snap_q;
  assign Run_held       = held_q[0];
  assign Continue_held  = held_q[1];

endmodule

// File: tb/tb_slc3_button_conditioner.sv
// Self-checking bench for slc3_button_conditioner (DEBOUNCE_CYCLES=4,
// RESET_HOLD_CYCLES=4, REPEAT_CYCLES=64). Output events are logged by a monitor
// and matched against expected events queued by each scenario.
module tb_slc3_button_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RH = 4;
  localparam int unsigned RP = 64;

  localparam logic [2:0] EV_RUN  = 3'd0;
  localparam logic [2:0] EV_CONT = 3'd1;
  localparam logic [2:0] EV_RST  = 3'd2;
  localparam logic [2:0] EV_RREL = 3'd3;
  localparam logic [2:0] EV_DUAL = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] cyc;
    logic [9:0]  sw;
  } ev_t;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Run_n;
  logic       Continue_n;
  logic [9:0] SW;
  logic       Run_pulse;
  logic       Continue_pulse;
  logic       Sys_reset;
  logic [9:0] SW_snap;
  logic       Run_held;
  logic       Continue_held;

  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic sys_reset_prev = 1'b0;

  slc3_button_conditioner #(
    .DEBOUNCE_CYCLES  (DB),
    .RESET_HOLD_CYCLES(RH),
    .REPEAT_CYCLES    (RP)
  ) u_dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Run_n         (Run_n),
    .Continue_n    (Continue_n),
    .SW            (SW),
    .Run_pulse     (Run_pulse),
    .Continue_pulse(Continue_pulse),
    .Sys_reset     (Sys_reset),
    .SW_snap       (SW_snap),
    .Run_held      (Run_held),
    .Continue_held (Continue_held)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Log every output event with the cycle it became visible in
  always @(negedge Clk) begin
    ev_t e;
    if (Run_pulse) begin
      e.kind = EV_RUN; e.cyc = cyc; e.sw = SW_snap; obs_q.push_back(e);
    end
    if (Continue_pulse) begin
      e.kind = EV_CONT; e.cyc = cyc; e.sw = '0; obs_q.push_back(e);
    end
    if (Run_pulse && Continue_pulse) begin
      e.kind = EV_DUAL; e.cyc = cyc; e.sw = '0; obs_q.push_back(e);
    end
    if (Sys_reset && !sys_reset_prev) begin
      e.kind = EV_RST; e.cyc = cyc; e.sw = '0; obs_q.push_back(e);
    end
    if (!Sys_reset && sys_reset_prev) begin
      e.kind = EV_RREL; e.cyc = cyc; e.sw = '0; obs_q.push_back(e);
    end
    sys_reset_prev = Sys_reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expect_ev(input logic [2:0] kind, input int unsigned at, input logic [9:0] sw);
    ev_t e;
    e.kind = kind; e.cyc = at; e.sw = sw;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; Run_n = 1'b1; Continue_n = 1'b1; SW = '0;
    #1;
    checks++;
    if ({Run_pulse, Continue_pulse, Sys_reset, SW_snap, Run_held, Continue_held} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {Run_pulse, Continue_pulse, Sys_reset, SW_snap, Run_held, Continue_held});
    end
    tick(3);
    Reset_n = 1'b1;
    tick(10);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_events: got %0d events, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_glitch;
    bit seen = 1'b0;
    Run_n = 1'b0;
    tick(2);
    Run_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (Run_held) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL glitch_held: Run_held went to 1, expected to stay 0");
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_events: got %0d events, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_run_snap(input logic [9:0] sw);
    int unsigned p, r;
    ev_t e, o;
    SW = sw;
    tick(1);
    p = cyc;
    Run_n = 1'b0;
    tick(5);
    checks++;
    if (Run_held !== 1'b0) begin
      errors++; $display("FAIL run_held_early: got %b at press+5, expected 0", Run_held);
    end
    tick(1);
    checks++;
    if (Run_held !== 1'b1) begin
      errors++; $display("FAIL run_held_rise: got %b at press+6, expected 1", Run_held);
    end
    tick(6);
    Run_n = 1'b1;
    r = cyc;
    checks++;
    if (r != p + 12) begin
      errors++; $display("FAIL run_press_len: got %0d cycles, expected 12", r - p);
    end
    expect_ev(EV_RUN, r + 7, sw);
    tick(7);
    checks++;
    if (Run_pulse !== 1'b1 || SW_snap !== sw) begin
      errors++;
      $display("FAIL run_pulse_snap: got pulse=%b snap=%h, expected pulse=1 snap=%h", Run_pulse, SW_snap, sw);
    end
    SW = ~sw;
    tick(1);
    checks++;
    if (Run_pulse !== 1'b0) begin
      errors++; $display("FAIL run_pulse_width: got %b one cycle later, expected 0", Run_pulse);
    end
    tick(4);
    checks++;
    if (SW_snap !== sw) begin
      errors++; $display("FAIL run_snap_hold: got %h after SW change, expected %h", SW_snap, sw);
    end
    tick(5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL run_event_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL run_event: got kind=%0d cyc=%0d sw=%h, expected kind=%0d cyc=%0d sw=%h",
                 o.kind, o.cyc, o.sw, e.kind, e.cyc, e.sw);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_continue;
    int unsigned p;
    ev_t e, o;
    SW = 10'h155;
    tick(1);
    p = cyc;
    Continue_n = 1'b0;
`ifdef CONTINUE_REPEAT_EN
    expect_ev(EV_CONT, p + 71, '0);
    expect_ev(EV_CONT, p + 135, '0);
    expect_ev(EV_CONT, p + 199, '0);
`else
    expect_ev(EV_CONT, p + 207, '0);
`endif
    tick(200);
    Continue_n = 1'b1;
    tick(15);
    checks++;
    if (SW_snap !== 10'h007) begin
      errors++; $display("FAIL cont_snap_unchanged: got %h, expected 007", SW_snap);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL cont_event_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cont_event: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_chord;
    int unsigned p, q;
    ev_t e, o;
    p = cyc;
    Run_n = 1'b0; Continue_n = 1'b0;
    expect_ev(EV_RST, p + 10, '0);
    tick(9);
    checks++;
    if (Sys_reset !== 1'b0) begin
      errors++; $display("FAIL chord_early: got Sys_reset=%b at press+9, expected 0", Sys_reset);
    end
    tick(1);
    checks++;
    if (Sys_reset !== 1'b1) begin
      errors++; $display("FAIL chord_rise: got Sys_reset=%b at press+10, expected 1", Sys_reset);
    end
    tick(10);
    Run_n = 1'b1; Continue_n = 1'b1;
    q = cyc;
    expect_ev(EV_RREL, q + 7, '0);
    tick(6);
    checks++;
    if (Sys_reset !== 1'b1) begin
      errors++; $display("FAIL chord_hold: got Sys_reset=%b at release+6, expected 1", Sys_reset);
    end
    tick(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL chord_event_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL chord_event: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_chord_tap;
    int unsigned p;
    ev_t e, o;
    p = cyc;
    Run_n = 1'b0;
    tick(10);
    Continue_n = 1'b0;
    tick(8);
    Continue_n = 1'b1;
    expect_ev(EV_RST, p + 20, '0);
    tick(12);
    Run_n = 1'b1;
    expect_ev(EV_RREL, p + 37, '0);
    tick(14);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tap_event_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL tap_event: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_chord_abort;
    bit rst_seen = 1'b0;
    Run_n = 1'b0;
    tick(10);
    Continue_n = 1'b0;
    tick(2);
    Run_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick(1);
      if (Sys_reset) rst_seen = 1'b1;
    end
    Continue_n = 1'b1;
    tick(12);
    checks++;
    if (rst_seen) begin
      errors++; $display("FAIL abort_reset: got Sys_reset=1 during short chord, expected 0");
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL abort_events: got %0d events, expected 0", obs_q.size());
    end
    checks++;
    if ({Run_held, Continue_held} !== 2'b00) begin
      errors++; $display("FAIL abort_idle: got held=%b, expected 00", {Run_held, Continue_held});
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_episode;
    Run_n = 1'b0;
    tick(9);
    checks++;
    if (Run_held !== 1'b1) begin
      errors++; $display("FAIL mid_pre_held: got Run_held=%b, expected 1", Run_held);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({Run_pulse, Continue_pulse, Sys_reset, SW_snap, Run_held, Continue_held} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got %b, expected all zero",
               {Run_pulse, Continue_pulse, Sys_reset, SW_snap, Run_held, Continue_held});
    end
    Run_n = 1'b1;
    tick(3);
    Reset_n = 1'b1;
    tick(20);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL mid_post_events: got %0d events, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_run_snap(10'h003);
    test_run_snap(10'h007);
    test_continue();
    test_chord();
    test_chord_tap();
    test_chord_abort();
    test_reset_mid_episode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_button_conditioner.md
Name: slc3_button_conditioner

Overview:
- Front-end conditioner for the SLC-3 top level; sits directly upstream of the CPU's Run/Continue/Reset inputs.
- Synchronizes and debounces the raw active-low Run and Continue pushbuttons, and decodes press episodes into single-cycle Run/Continue pulses.
- A simultaneous both-button chord becomes a CPU reset request.
- Snapshots SW into a register on each Run pulse.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to change a debounced level (>=2)
RESET_HOLD_CYCLES, 4, consecutive cycles both buttons must be debounced-held to raise Sys_reset (>=1)
REPEAT_CYCLES, 64, auto-repeat period for Continue (used only with CONTINUE_REPEAT_EN)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset_n  in  1  asynchronous active-low reset
Run_n  in  1  raw Run button, 0 = pressed, asynchronous to Clk
Continue_n  in  1  raw Continue button, 0 = pressed, asynchronous to Clk
SW  in  10  slide switches
Run_pulse  out  1  one-cycle Run strobe to CPU
Continue_pulse  out  1  one-cycle Continue strobe to CPU
Sys_reset  out  1  active-high reset request to CPU
SW_snap  out  10  SW value captured with the most recent Run_pulse
Run_held  out  1  debounced Run level, 1 = pressed
Continue_held  out  1  debounced Continue level, 1 = pressed

Behaviour:
- Reset (async, any time including mid-episode):
  - Synchronizer flops go to 1 (released).
  - Debounce counters go to 0.
  - FSM goes to IDLE.
  - All outputs go to 0.
- Synchronizer: 2 flops per button. Logic uses the inverted synced value as "pressed".
- Debounce, per button:
  - Counter increments while synced pressed != debounced held; clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, held toggles and the counter clears.
  - Latency from a stable raw edge to a held change: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
- FSM states: IDLE, SINGLE_R, SINGLE_C, BOTH, WAIT_REL. It operates on Run_held/Continue_held only.
- IDLE:
  - Only Run held -> SINGLE_R.
  - Only Continue held -> SINGLE_C.
  - Both held in the same cycle -> BOTH.
- SINGLE_R:
  - Continue becomes held -> BOTH.
  - Run released with Continue not held -> Run_pulse=1 for exactly that transition cycle; SW_snap<=SW on the same edge; -> IDLE.
- SINGLE_C: symmetric to SINGLE_R, emitting Continue_pulse. SW_snap is unchanged.
- BOTH:
  - Hold counter increments each cycle both are held.
  - When the count reaches RESET_HOLD_CYCLES, Sys_reset goes to 1 -> WAIT_REL.
  - Either button released before that -> WAIT_REL with no pulse and no reset (aborted chord).
- WAIT_REL:
  - Sys_reset holds its value.
  - Neither held -> IDLE with Sys_reset=0. No pulses are ever emitted from WAIT_REL.
- Pulses are emitted on release only, so a chord never leaks a Run or Continue pulse.
- Run_pulse and Continue_pulse are never high in the same cycle.
- All outputs are registered.

Optional Feature:
- Macro: CONTINUE_REPEAT_EN.
- Defined: in SINGLE_C a repeat counter counts held cycles.
  - Every REPEAT_CYCLES cycles it emits a Continue_pulse.
  - On release, a pulse is emitted only if no repeat pulse fired during that episode.
  - The repeat counter clears on entry to SINGLE_C.
- Undefined: no repeat counter; exactly one Continue_pulse per valid single-button episode, at release.

Test Plan:
(Parameters for all scenarios unless noted: DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=4, REPEAT_CYCLES=64.)
1. Assert Reset_n=0 mid-episode (Run held 3 cycles into SINGLE_R) -> all outputs 0 immediately, with no clock edge needed. After release of Reset_n with buttons up, there are no pulses.
2. Run_n low 2 cycles then high -> Run_held stays 0; no Run_pulse.
3. SW=0x003, Run_n low 12 cycles then high -> Run_held rises 6 cycles after the press edge. After the release edge, Run_pulse is high for exactly 1 cycle and SW_snap=0x003. Repeat with SW=0x007 -> SW_snap=0x007.
4. Run_n and Continue_n low together for 20 cycles -> Sys_reset rises 6+4 cycles after the press and stays 1 until both are released, then goes to 0 about 6 cycles after release. Zero Run/Continue pulses.
5. Run held, Continue tapped 8 cycles, Run released later -> no Sys_reset if both held less than 4 cycles, and no Run_pulse in either case.
6. CONTINUE_REPEAT_EN defined, Continue_n low 200 cycles -> 3 Continue_pulses spaced 64 cycles apart and none at release. Macro undefined -> 1 pulse at release.
